ternary_word_accumulator: RTL and testbench
===========================================

Name: ternary_word_accumulator

Overview:
- Downstream consumer of the 4-trit ternary deselect stage: takes the selected balanced-ternary word and accumulates it into a registered word.
- Operations: load, add, subtract or clear, with wrap-around carry trit, sticky illegal-encoding error and accepted-operation counter.
- Output feeds display/compare stages.
- Trit encoding, fixed for every port in this document: 01 = -1, 11 = 0, 10 = +1, 00 = illegal. Each trit is MSB-first within its 2-bit field; trit i occupies bits [2i+1:2i].

Parameters:
- N_TRITS, 4: word length in trits. Value range is ±R, where R = (3^N_TRITS - 1)/2 (R = 40 at default).
- CNT_W, 8: width of the accepted-operation counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_word/op presented this cycle
- in_ready  out  1  block can accept this cycle
- op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
- in_word  in  2*N_TRITS  ternary operand (output of the deselect stage)
- acc_word  out  2*N_TRITS  accumulator value, ternary-encoded
- carry_trit  out  2  wrap trit from the last ADD/SUB
- out_valid  out  1  one-cycle pulse: acc_word updated by an accepted op
- err  out  1  sticky illegal-encoding flag
- op_count  out  CNT_W  number of accepted ops, wraps at 2^CNT_W

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values, applied immediately on rst regardless of clk:
  - acc_word = all trits 0 (8'hFF at default)
  - carry_trit = 2'b11
  - out_valid = 0, err = 0, op_count = 0
  - in_ready = 0 while rst is high; in_ready = 1 from the first clk edge after rst deasserts.
- Handshake: an op is accepted on a rising clk edge with in_valid & in_ready.
  - in_ready deasserts for exactly one cycle after every accepted CLEAR (settle cycle); it is otherwise 1.
  - in_valid while in_ready = 0 is ignored, with no side effects.
- Internal datapath: decode in_word to a signed integer v = Σ t_i·3^i. acc is held as a signed integer with width ≥ ceil(log2(3R+1)) + 1. Re-encode to trits each cycle (combinational from the register, or registered; acc_word is valid the cycle out_valid is high).
- LOAD / ADD / SUB on accept:
  - If any trit of in_word is 00: no update to acc/carry/op_count, err <= 1, out_valid stays 0.
  - Else LOAD: acc <= v, carry <= 0.
  - Else ADD: s = acc + v. SUB: s = acc - v.
    - If s > R: acc <= s - 3^N_TRITS, carry <= +1.
    - If s < -R: acc <= s + 3^N_TRITS, carry <= -1.
    - Otherwise acc <= s, carry <= 0.
  - On any valid update: out_valid = 1 next cycle, op_count += 1 (wraps to 0 from all-ones).
- CLEAR on accept:
  - acc <= 0, carry <= 0, err <= 0, op_count <= 0, out_valid <= 1.
  - in_word is ignored, including for illegal-code checking.
- Latency: result is visible on acc_word/carry_trit/out_valid one cycle after the accepting edge. Back-to-back accepts (except after CLEAR) update every cycle.
- err is set only by an illegal accepted operand and cleared only by CLEAR or rst.
- Reset asserted mid-stream: all state is returned to reset values at once; an in-flight op is lost.

Test Plan:
- Reset: assert rst, then release -> acc_word = 8'hFF, carry = 2'b11, err = 0, op_count = 0, out_valid = 0; in_ready rises after the first clk edge.
- LOAD 8'h96 (+16), then ADD 8'h69 (-16) on consecutive cycles:
  - after LOAD: acc_word = 8'h96, out_valid pulses, op_count = 1
  - after ADD: acc_word = 8'hFF (0), carry = 2'b11, op_count = 2
- Wrap-around: LOAD 8'h96, ADD 8'h96, ADD 8'h96:
  - after first ADD: acc_word = 8'hA5 (+32), carry = 2'b11
  - after second ADD: 48 wraps to -33, acc_word = 8'h5B, carry = 2'b10 (+1)
- SUB from zero: CLEAR, idle one cycle (in_ready = 0), then SUB 8'h96 -> acc_word = 8'h69 (-16), carry = 2'b11; then SUB 8'h96 twice -> second SUB gives -48 -> +33 = 8'hA7, carry = 2'b01.
- Illegal operand: with acc = 8'h96, ADD 8'h16 (top trit 00) -> acc_word stays 8'h96, err = 1, no out_valid, op_count unchanged; a following CLEAR -> err = 0, acc_word = 8'hFF.
- Async reset mid-op: assert rst between clk edges while in_valid = 1 with ADD -> outputs go to reset values before the next edge, and no update occurs on that edge.

Source files
------------

// File: rtl/ternary_word_accumulator_if.sv
// Operand/result bundle of the ternary word accumulator.
// The master drives operands in and observes the accumulator. The slave is the accumulator itself.
interface ternary_word_accumulator_if #(
  parameter int N_TRITS = 4,
  parameter int CNT_W   = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             op;
  logic [2*N_TRITS-1:0]   in_word;
  logic [2*N_TRITS-1:0]   acc_word;
  logic [1:0]             carry_trit;
  logic                   out_valid;
  logic                   err;
  logic [CNT_W-1:0]       op_count;

  modport master (
    output in_valid, op, in_word,
    input  in_ready, acc_word, carry_trit, out_valid, err, op_count
  );

  modport slave (
    input  in_valid, op, in_word,
    output in_ready, acc_word, carry_trit, out_valid, err, op_count
  );
endinterface

// File: rtl/ternary_word_accumulator.sv
// Balanced-ternary accumulator: LOAD/ADD/SUB/CLEAR on a wrapped signed register.
// Trit codes are 01 = -1, 11 = 0, 10 = +1, and 00 = illegal.
// The accumulator is held in binary. It is re-encoded to trits combinationally from the register.
module ternary_word_accumulator #(
  parameter int N_TRITS = 4,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  ternary_word_accumulator_if.slave bus
);

  function automatic int pow3(input int n);
    int p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 3;
    return p;
  endfunction

  localparam int P3    = pow3(N_TRITS);
  localparam int R     = (P3 - 1) / 2;
  // Holds 3R comfortably. The signed span is at most 2R, for example acc = R plus v = R.
  localparam int ACC_W = $clog2(3 * R + 1) + 1;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] T_NEG  = 2'b01;
  localparam logic [1:0] T_ZERO = 2'b11;
  localparam logic [1:0] T_POS  = 2'b10;

  localparam logic [ACC_W-1:0] THREE = ACC_W'(3);

  acc_t             acc_q, acc_d;
  logic [1:0]       carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;

  acc_t                 v_dec;
  logic                 illegal;
  acc_t                 sum;
  logic                 accept;
  logic [ACC_W-1:0]     u_enc;
  logic [2*N_TRITS-1:0] word_enc;

  assign accept = bus.in_valid & ready_q;

  // Decode the operand trits to a signed value, and flag any illegal code.
  always_comb begin
    v_dec   = '0;
    illegal = 1'b0;
    for (int i = 0; i < N_TRITS; i++) begin
      case (bus.in_word[2*i +: 2])
        T_POS:   v_dec = v_dec + acc_t'(pow3(i));
        T_NEG:   v_dec = v_dec - acc_t'(pow3(i));
        T_ZERO:  ;
        default: illegal = 1'b1;
      endcase
    end
  end

  // Encode the register as trits. Offsetting by R gives a plain base-3 number, and each digit minus 1 is the trit.
  always_comb begin
    u_enc    = $unsigned(acc_q) + ACC_W'(R);
    word_enc = '0;
    for (int i = 0; i < N_TRITS; i++) begin
      case (u_enc % THREE)
        ACC_W'(0): word_enc[2*i +: 2] = T_NEG;
        ACC_W'(1): word_enc[2*i +: 2] = T_ZERO;
        default:   word_enc[2*i +: 2] = T_POS;
      endcase
      u_enc = u_enc / THREE;
    end
  end

  assign sum = (bus.op == OP_SUB) ? (acc_q - v_dec) : (acc_q + v_dec);

  // Compute the next state for an accepted op. In_ready drops for one cycle after a CLEAR.
  always_comb begin
    acc_d       = acc_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b1;
    if (accept) begin
      if (bus.op == OP_CLEAR) begin
        acc_d       = '0;
        carry_d     = T_ZERO;
        err_d       = 1'b0;
        cnt_d       = '0;
        out_valid_d = 1'b1;
        ready_d     = 1'b0;
      end else if (illegal) begin
        err_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (bus.op == OP_LOAD) begin
          acc_d   = v_dec;
          carry_d = T_ZERO;
        end else if (sum > acc_t'(R)) begin
          acc_d   = sum - acc_t'(P3);
          carry_d = T_POS;
        end else if (sum < -acc_t'(R)) begin
          acc_d   = sum + acc_t'(P3);
          carry_d = T_NEG;
        end else begin
          acc_d   = sum;
          carry_d = T_ZERO;
        end
      end
    end
  end

  // State registers. Reset takes effect immediately, and in_ready stays low until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      carry_q     <= T_ZERO;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.acc_word   = word_enc;
  assign bus.carry_trit = carry_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.err        = err_q;
  assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_ternary_word_accumulator.sv
// Directed bench for ternary_word_accumulator.
// A table of single-cycle operations is checked field by field. Hand-written sequences cover reset, counter wrap and an asynchronous mid-op reset.
module tb_ternary_word_accumulator;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_failed;

  ternary_word_accumulator_if #(.N_TRITS(4), .CNT_W(8)) bus_if ();

  ternary_word_accumulator #(.N_TRITS(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [7:0] w;
    logic [7:0] acc;
    logic [1:0] c;
    logic       ov;
    logic       er;
    logic [7:0] cnt;
    logic       rdy;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] acc, input logic [1:0] c,
                           input logic ov, input logic er, input logic [7:0] cnt, input logic rdy);
    check({tag, ".acc_word"},   32'(bus_if.acc_word),   32'(acc));
    check({tag, ".carry_trit"}, 32'(bus_if.carry_trit), 32'(c));
    check({tag, ".out_valid"},  32'(bus_if.out_valid),  32'(ov));
    check({tag, ".err"},        32'(bus_if.err),        32'(er));
    check({tag, ".op_count"},   32'(bus_if.op_count),   32'(cnt));
    check({tag, ".in_ready"},   32'(bus_if.in_ready),   32'(rdy));
    $display("[TB] %s acc=%h carry=%b ov=%b err=%b cnt=%0d rdy=%b", tag, bus_if.acc_word,
             bus_if.carry_trit, bus_if.out_valid, bus_if.err, bus_if.op_count, bus_if.in_ready);
  endtask

  // Drive one operation at the falling edge, then sample just after the next rising edge.
  task automatic do_op(input logic v, input logic [1:0] op, input logic [7:0] w);
    @(negedge clk);
    bus_if.in_valid = v;
    bus_if.op       = op;
    bus_if.in_word  = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    bus_if.in_valid = 1'b0;
    bus_if.op       = 2'b00;
    bus_if.in_word  = 8'hFF;

    //            v     op     word    acc    carry  ov    err   cnt    rdy
    tbl[0]  = '{1'b1, 2'b00, 8'h96, 8'h96, 2'b11, 1'b1, 1'b0, 8'd1, 1'b1}; // LOAD +16
    tbl[1]  = '{1'b1, 2'b01, 8'h69, 8'hFF, 2'b11, 1'b1, 1'b0, 8'd2, 1'b1}; // ADD -16 -> 0
    tbl[2]  = '{1'b1, 2'b00, 8'h96, 8'h96, 2'b11, 1'b1, 1'b0, 8'd3, 1'b1}; // LOAD +16
    tbl[3]  = '{1'b1, 2'b01, 8'h96, 8'hA5, 2'b11, 1'b1, 1'b0, 8'd4, 1'b1}; // +32
    tbl[4]  = '{1'b1, 2'b01, 8'h96, 8'h5B, 2'b10, 1'b1, 1'b0, 8'd5, 1'b1}; // 48 -> -33, carry +1
    tbl[5]  = '{1'b1, 2'b11, 8'h00, 8'hFF, 2'b11, 1'b1, 1'b0, 8'd0, 1'b0}; // CLEAR, illegal word ignored
    tbl[6]  = '{1'b1, 2'b10, 8'h96, 8'hFF, 2'b11, 1'b0, 1'b0, 8'd0, 1'b1}; // ignored while not ready
    tbl[7]  = '{1'b1, 2'b10, 8'h96, 8'h69, 2'b11, 1'b1, 1'b0, 8'd1, 1'b1}; // SUB -> -16
    tbl[8]  = '{1'b1, 2'b10, 8'h96, 8'h5A, 2'b11, 1'b1, 1'b0, 8'd2, 1'b1}; // -32
    tbl[9]  = '{1'b1, 2'b10, 8'h96, 8'hA7, 2'b01, 1'b1, 1'b0, 8'd3, 1'b1}; // -48 -> +33, carry -1
    tbl[10] = '{1'b1, 2'b00, 8'h96, 8'h96, 2'b11, 1'b1, 1'b0, 8'd4, 1'b1}; // LOAD +16
    tbl[11] = '{1'b1, 2'b01, 8'h16, 8'h96, 2'b11, 1'b0, 1'b1, 8'd4, 1'b1}; // illegal top trit
    tbl[12] = '{1'b0, 2'b01, 8'h96, 8'h96, 2'b11, 1'b0, 1'b1, 8'd4, 1'b1}; // idle
    tbl[13] = '{1'b1, 2'b00, 8'h69, 8'h69, 2'b11, 1'b1, 1'b1, 8'd5, 1'b1}; // err sticky across LOAD
    tbl[14] = '{1'b1, 2'b01, 8'hFF, 8'h69, 2'b11, 1'b1, 1'b1, 8'd6, 1'b1}; // ADD 0
    tbl[15] = '{1'b1, 2'b11, 8'h96, 8'hFF, 2'b11, 1'b1, 1'b0, 8'd0, 1'b0}; // CLEAR clears err
    tbl[16] = '{1'b0, 2'b00, 8'h00, 8'hFF, 2'b11, 1'b0, 1'b0, 8'd0, 1'b1}; // settle cycle
    tbl[17] = '{1'b1, 2'b00, 8'hAA, 8'hAA, 2'b11, 1'b1, 1'b0, 8'd1, 1'b1}; // LOAD +40 (R)
    tbl[18] = '{1'b1, 2'b01, 8'hFE, 8'h55, 2'b10, 1'b1, 1'b0, 8'd2, 1'b1}; // 41 -> -40, carry +1
    tbl[19] = '{1'b1, 2'b10, 8'hFE, 8'hAA, 2'b01, 1'b1, 1'b0, 8'd3, 1'b1}; // -41 -> +40, carry -1
    tbl[20] = '{1'b1, 2'b01, 8'hFC, 8'hAA, 2'b01, 1'b0, 1'b1, 8'd3, 1'b1}; // illegal low trit

    // Reset state, then in_ready rises only after the first edge.
    rst = 1'b1;
    #12;
    check_all("reset", 8'hFF, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release.in_ready_before_edge", 32'(bus_if.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("reset_release.in_ready_after_edge", 32'(bus_if.in_ready), 32'd1);

    for (int i = 0; i < 21; i++) begin
      do_op(tbl[i].v, tbl[i].op, tbl[i].w);
      check_all($sformatf("vec%0d", i), tbl[i].acc, tbl[i].c, tbl[i].ov, tbl[i].er, tbl[i].cnt, tbl[i].rdy);
    end

    // Asynchronous reset between edges while an ADD is presented.
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.op       = 2'b01;
    bus_if.in_word  = 8'h96;
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst_before_edge", 8'hFF, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    check_all("async_rst_after_edge", 8'hFF, 2'b11, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all("async_rst_release", 8'hFF, 2'b11, 1'b0, 1'b0, 8'd0, 1'b1);

    // The op counter wraps at 256. ADD 0 keeps acc at 0.
    for (int k = 1; k <= 256; k++) begin
      do_op(1'b1, 2'b01, 8'hFF);
      if (k == 255) check_all("cnt_255", 8'hFF, 2'b11, 1'b1, 1'b0, 8'd255, 1'b1);
      if (k == 256) check_all("cnt_wrap", 8'hFF, 2'b11, 1'b1, 1'b0, 8'd0, 1'b1);
    end
    do_op(1'b0, 2'b00, 8'hFF);
    check_all("cnt_idle", 8'hFF, 2'b11, 1'b0, 1'b0, 8'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
